// File: rtl/coeff_bank_loader.sv
// Streams host config words (LOAD) or zeros (CLEAR) into DEPTH one-hot-enabled cells; write strobe 1 cycle after acceptance,
// in_ready only in LOAD without abort. Optional running checksum port under COEFF_BANK_LOADER_CHECKSUM_EN.
module coeff_bank_loader #(
    parameter int WIDTH  = 24,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              clear,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  in_data,
    output logic              in_ready,
    output logic [DEPTH-1:0]  cell_ce,
    output logic              cell_we,
    output logic [WIDTH-1:0]  cell_d,
    output logic              busy,
    output logic              done,
`ifdef COEFF_BANK_LOADER_CHECKSUM_EN
    output logic [WIDTH-1:0]  checksum,
`endif
    output logic [ADDR_W:0]   count
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CLEAR, S_DONE} state_t;

    localparam logic [ADDR_W-1:0] L_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   L_DEPTH = (ADDR_W + 1)'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_index;
    logic                w_last;
    logic                w_wr;
    logic                w_seq_start;
    logic [WIDTH-1:0]    w_wr_dat;
    logic [DEPTH-1:0]    w_onehot;

    assign w_last   = (r_index == L_LAST);
    assign w_onehot = DEPTH'(1) << r_index;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)      w_next = S_LOAD;
                else if (clear) w_next = S_CLEAR;
            end
            S_LOAD: begin
                if (abort)               w_next = S_IDLE;
                else if (w_wr && w_last) w_next = S_DONE;
            end
            S_CLEAR: begin
                if (abort)       w_next = S_IDLE;
                else if (w_last) w_next = S_DONE;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Abort masks both acceptance and the CLEAR write of the same cycle.
    always_comb begin
        in_ready    = (r_state == S_LOAD) && !abort;
        w_wr        = (in_ready && in_valid) || ((r_state == S_CLEAR) && !abort);
        w_wr_dat    = (r_state == S_LOAD) ? in_data : '0;
        w_seq_start = (r_state == S_IDLE) && (start || clear);
        busy        = (r_state == S_LOAD) || (r_state == S_CLEAR);
        done        = (r_state == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cell_ce <= '0;
            cell_we <= 1'b0;
            cell_d  <= '0;
            r_index <= '0;
            count   <= '0;
        end else begin
            cell_we <= w_wr;
            cell_ce <= w_wr ? w_onehot : '0;
            if (w_wr) cell_d <= w_wr_dat;
            if (w_seq_start) begin
                r_index <= '0;
                count   <= '0;
            end else if (w_wr) begin
                if (!w_last)         r_index <= r_index + ADDR_W'(1);
                if (count != L_DEPTH) count  <= count + (ADDR_W + 1)'(1);
            end
        end
    end

`ifdef COEFF_BANK_LOADER_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (reset || w_seq_start) checksum <= '0;
        else if (w_wr)            checksum <= checksum + w_wr_dat;
    end
`endif

endmodule
